off_chip_link_rx: RTL

//  Receive end of the off-chip nibble link. Accepts 4-bit link words from the link transmitter and

---
 rtl/off_chip_link_rx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/off_chip_link_rx.sv
// Off-chip nibble link receiver: buffers 4-bit link words, pairs them
// back into bytes on a valid/ready output and returns credits upstream.
module off_chip_link_rx #(
    parameter int DEPTH       = 8,
    parameter int CREDIT_GRAN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               link_data,
    input  logic                     link_valid,
    output logic                     credit_return,
    output logic [7:0]               data_out,
    output logic                     valid_out,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDIT_GRAN);

    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   OCC_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);
    localparam logic [CW-1:0] FREE_TWO = CW'(2);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [CW-1:0] freed_q, freed_d;
    logic          credit_q, credit_d;
    logic [7:0]    dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          wr_en;
    logic          pop;
    logic [3:0]    w0;
    logic [3:0]    w1;

    assign full  = (occ_q == OCC_FULL);
    assign wr_en = link_valid && !full;
    assign pop   = (occ_q >= OCC_TWO) && (!vld_q || ready);

    // rptr is always even, so the partner word sits at rptr|1 without wrapping
    assign w0 = mem_q[rptr_q];
    assign w1 = mem_q[rptr_q | PTR_ONE];

    // Next-state logic for pointers, occupancy, credits and output register
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        occ_d    = occ_q;
        freed_d  = freed_q;
        credit_d = 1'b0;
        dout_d   = dout_q;
        vld_d    = vld_q;
        ovf_d    = ovf_q;

        if (wr_en) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (link_valid && full) begin
            ovf_d = 1'b1;
        end

        occ_d = occ_q + (wr_en ? (AW+1)'(1) : OCC_ZERO)
                      - (pop ? OCC_TWO : OCC_ZERO);

        if (pop) begin
            rptr_d   = rptr_q + PTR_TWO;
            freed_d  = freed_q + FREE_TWO;
            credit_d = (freed_d == '0);
            dout_d   = {w1[3:2], w0[3:2], w1[1:0], w0[1:0]};
            vld_d    = 1'b1;
        end else if (vld_q && ready) begin
            vld_d = 1'b0;
        end
    end

    // Link word storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= link_data;
        end
    end

    // Control and output state, cleared asynchronously (drops any half byte)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            freed_q  <= '0;
            credit_q <= 1'b0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            freed_q  <= freed_d;
            credit_q <= credit_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    assign credit_return = credit_q;
    assign data_out      = dout_q;
    assign valid_out     = vld_q;
    assign occupancy     = occ_q;
    assign overflow      = ovf_q;

endmodule
